// File: rtl/add_32layers.sv
// add_32layers: sums 32 signed layer pixels through a five-level registered
// binary adder tree. One beat per cycle, fixed 5-cycle latency, no backpressure.
// A beat is accepted only when all 32 valid_in bits are high.
// Optional build macro ADD32LAYERS_SAT_EN: saturate the final sum to data_width
// bits instead of wrapping.
// Handshake: valid-only stream. A beat is taken on every rising clk edge where
// all valid_in are 1. valid_out marks the single cycle in which pxl_out carries
// a new sum. There is no ready signal, so the consumer must always accept.
module add_32layers #(
   parameter int D          = 299,
   parameter int data_width = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in_1,  input logic valid_in_2,  input logic valid_in_3,  input logic valid_in_4,
   input  logic                  valid_in_5,  input logic valid_in_6,  input logic valid_in_7,  input logic valid_in_8,
   input  logic                  valid_in_9,  input logic valid_in_10, input logic valid_in_11, input logic valid_in_12,
   input  logic                  valid_in_13, input logic valid_in_14, input logic valid_in_15, input logic valid_in_16,
   input  logic                  valid_in_17, input logic valid_in_18, input logic valid_in_19, input logic valid_in_20,
   input  logic                  valid_in_21, input logic valid_in_22, input logic valid_in_23, input logic valid_in_24,
   input  logic                  valid_in_25, input logic valid_in_26, input logic valid_in_27, input logic valid_in_28,
   input  logic                  valid_in_29, input logic valid_in_30, input logic valid_in_31, input logic valid_in_32,
   input  logic [data_width-1:0] pxl_in_1,  input logic [data_width-1:0] pxl_in_2,
   input  logic [data_width-1:0] pxl_in_3,  input logic [data_width-1:0] pxl_in_4,
   input  logic [data_width-1:0] pxl_in_5,  input logic [data_width-1:0] pxl_in_6,
   input  logic [data_width-1:0] pxl_in_7,  input logic [data_width-1:0] pxl_in_8,
   input  logic [data_width-1:0] pxl_in_9,  input logic [data_width-1:0] pxl_in_10,
   input  logic [data_width-1:0] pxl_in_11, input logic [data_width-1:0] pxl_in_12,
   input  logic [data_width-1:0] pxl_in_13, input logic [data_width-1:0] pxl_in_14,
   input  logic [data_width-1:0] pxl_in_15, input logic [data_width-1:0] pxl_in_16,
   input  logic [data_width-1:0] pxl_in_17, input logic [data_width-1:0] pxl_in_18,
   input  logic [data_width-1:0] pxl_in_19, input logic [data_width-1:0] pxl_in_20,
   input  logic [data_width-1:0] pxl_in_21, input logic [data_width-1:0] pxl_in_22,
   input  logic [data_width-1:0] pxl_in_23, input logic [data_width-1:0] pxl_in_24,
   input  logic [data_width-1:0] pxl_in_25, input logic [data_width-1:0] pxl_in_26,
   input  logic [data_width-1:0] pxl_in_27, input logic [data_width-1:0] pxl_in_28,
   input  logic [data_width-1:0] pxl_in_29, input logic [data_width-1:0] pxl_in_30,
   input  logic [data_width-1:0] pxl_in_31, input logic [data_width-1:0] pxl_in_32,
   output logic [data_width-1:0] pxl_out,
   output logic                  valid_out
);

   localparam int W = data_width;

   logic [W-1:0] px [32];
   logic [31:0]  vin;
   logic         beat;

   // Level registers grow one bit per level so no partial sum can overflow.
   logic [W:0]   l1 [16];
   logic [W+1:0] l2 [8];
   logic [W+2:0] l3 [4];
   logic [W+3:0] l4 [2];
   logic [W+4:0] l5;
   logic [5:1]   v;

   assign px[0]  = pxl_in_1;  assign px[1]  = pxl_in_2;  assign px[2]  = pxl_in_3;  assign px[3]  = pxl_in_4;
   assign px[4]  = pxl_in_5;  assign px[5]  = pxl_in_6;  assign px[6]  = pxl_in_7;  assign px[7]  = pxl_in_8;
   assign px[8]  = pxl_in_9;  assign px[9]  = pxl_in_10; assign px[10] = pxl_in_11; assign px[11] = pxl_in_12;
   assign px[12] = pxl_in_13; assign px[13] = pxl_in_14; assign px[14] = pxl_in_15; assign px[15] = pxl_in_16;
   assign px[16] = pxl_in_17; assign px[17] = pxl_in_18; assign px[18] = pxl_in_19; assign px[19] = pxl_in_20;
   assign px[20] = pxl_in_21; assign px[21] = pxl_in_22; assign px[22] = pxl_in_23; assign px[23] = pxl_in_24;
   assign px[24] = pxl_in_25; assign px[25] = pxl_in_26; assign px[26] = pxl_in_27; assign px[27] = pxl_in_28;
   assign px[28] = pxl_in_29; assign px[29] = pxl_in_30; assign px[30] = pxl_in_31; assign px[31] = pxl_in_32;

   assign vin = {valid_in_32, valid_in_31, valid_in_30, valid_in_29, valid_in_28, valid_in_27, valid_in_26, valid_in_25,
                 valid_in_24, valid_in_23, valid_in_22, valid_in_21, valid_in_20, valid_in_19, valid_in_18, valid_in_17,
                 valid_in_16, valid_in_15, valid_in_14, valid_in_13, valid_in_12, valid_in_11, valid_in_10, valid_in_9,
                 valid_in_8,  valid_in_7,  valid_in_6,  valid_in_5,  valid_in_4,  valid_in_3,  valid_in_2,  valid_in_1};

   assign beat = &vin;

   // Adder tree: each level loads only when the valid bit feeding it is set, so
   // invalid beats leave the previous sums in place.
   always_ff @(posedge clk) begin
      if (!reset) begin
         v <= '0;
         for (int i = 0; i < 16; i++) l1[i] <= '0;
         for (int i = 0; i < 8; i++)  l2[i] <= '0;
         for (int i = 0; i < 4; i++)  l3[i] <= '0;
         for (int i = 0; i < 2; i++)  l4[i] <= '0;
         l5 <= '0;
      end else begin
         v <= {v[4:1], beat};
         if (beat)
            for (int i = 0; i < 16; i++)
               l1[i] <= {px[2*i][W-1], px[2*i]} + {px[2*i+1][W-1], px[2*i+1]};
         if (v[1])
            for (int i = 0; i < 8; i++)
               l2[i] <= {l1[2*i][W], l1[2*i]} + {l1[2*i+1][W], l1[2*i+1]};
         if (v[2])
            for (int i = 0; i < 4; i++)
               l3[i] <= {l2[2*i][W+1], l2[2*i]} + {l2[2*i+1][W+1], l2[2*i+1]};
         if (v[3])
            for (int i = 0; i < 2; i++)
               l4[i] <= {l3[2*i][W+2], l3[2*i]} + {l3[2*i+1][W+2], l3[2*i+1]};
         if (v[4])
            l5 <= {l4[0][W+3], l4[0]} + {l4[1][W+3], l4[1]};
      end
   end

   assign valid_out = v[5];

`ifdef ADD32LAYERS_SAT_EN
   // The sum fits in W bits when its top six bits all equal the sign bit.
   // Otherwise clamp toward the sign of the full-precision sum.
   always_comb begin
      pxl_out = l5[W-1:0];
      if (!((&l5[W+4:W-1]) || !(|l5[W+4:W-1])))
         pxl_out = l5[W+4] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   end
`else
   // Keep the low W bits of the full-precision sum, which wraps on overflow.
   always_comb begin
      pxl_out = l5[W-1:0];
   end
`endif

endmodule

// File: tb/tb_add_32layers.sv
// tb_add_32layers: directed, table-driven bench for add_32layers, with a small
// delay-line reference model checked on every cycle.
// The expected values follow the ADD32LAYERS_SAT_EN setting of the build.
module tb_add_32layers;

   logic        clk;
   logic        rst;
   logic [31:0] vin;
   logic [31:0] pin [32];
   logic [31:0] pxl_out;
   logic        valid_out;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: a 5-deep delay line of (valid, expected sum), plus the held output.
   logic        m_v [1:5];
   logic [31:0] m_d [1:5];
   logic [31:0] m_out;

   typedef struct {
      logic [31:0] base;
      logic [31:0] step;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [8];

   add_32layers #(.D(299), .data_width(32)) dut (
      .clk(clk), .reset(rst),
      .valid_in_1(vin[0]),   .valid_in_2(vin[1]),   .valid_in_3(vin[2]),   .valid_in_4(vin[3]),
      .valid_in_5(vin[4]),   .valid_in_6(vin[5]),   .valid_in_7(vin[6]),   .valid_in_8(vin[7]),
      .valid_in_9(vin[8]),   .valid_in_10(vin[9]),  .valid_in_11(vin[10]), .valid_in_12(vin[11]),
      .valid_in_13(vin[12]), .valid_in_14(vin[13]), .valid_in_15(vin[14]), .valid_in_16(vin[15]),
      .valid_in_17(vin[16]), .valid_in_18(vin[17]), .valid_in_19(vin[18]), .valid_in_20(vin[19]),
      .valid_in_21(vin[20]), .valid_in_22(vin[21]), .valid_in_23(vin[22]), .valid_in_24(vin[23]),
      .valid_in_25(vin[24]), .valid_in_26(vin[25]), .valid_in_27(vin[26]), .valid_in_28(vin[27]),
      .valid_in_29(vin[28]), .valid_in_30(vin[29]), .valid_in_31(vin[30]), .valid_in_32(vin[31]),
      .pxl_in_1(pin[0]),   .pxl_in_2(pin[1]),   .pxl_in_3(pin[2]),   .pxl_in_4(pin[3]),
      .pxl_in_5(pin[4]),   .pxl_in_6(pin[5]),   .pxl_in_7(pin[6]),   .pxl_in_8(pin[7]),
      .pxl_in_9(pin[8]),   .pxl_in_10(pin[9]),  .pxl_in_11(pin[10]), .pxl_in_12(pin[11]),
      .pxl_in_13(pin[12]), .pxl_in_14(pin[13]), .pxl_in_15(pin[14]), .pxl_in_16(pin[15]),
      .pxl_in_17(pin[16]), .pxl_in_18(pin[17]), .pxl_in_19(pin[18]), .pxl_in_20(pin[19]),
      .pxl_in_21(pin[20]), .pxl_in_22(pin[21]), .pxl_in_23(pin[22]), .pxl_in_24(pin[23]),
      .pxl_in_25(pin[24]), .pxl_in_26(pin[25]), .pxl_in_27(pin[26]), .pxl_in_28(pin[27]),
      .pxl_in_29(pin[28]), .pxl_in_30(pin[29]), .pxl_in_31(pin[30]), .pxl_in_32(pin[31]),
      .pxl_out(pxl_out), .valid_out(valid_out)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive lane k with base + k*step and set every valid bit to vld.
   task automatic drive(input logic [31:0] base, input logic [31:0] step, input logic vld);
      for (int k = 0; k < 32; k++) begin
         pin[k] = base + step * k;
         vin[k] = vld;
      end
   endtask

   // One clock: the model sees the beat, then both DUT outputs are checked 1 time unit after the edge.
   task automatic cycle(input string name, input logic [31:0] esum);
      logic beat;
      beat = rst && (&vin);
      @(posedge clk);
      if (!rst) begin
         for (int k = 1; k <= 5; k++) m_v[k] = 1'b0;
         m_out = '0;
      end else begin
         for (int k = 5; k >= 2; k--) begin
            m_v[k] = m_v[k-1];
            m_d[k] = m_d[k-1];
         end
         m_v[1] = beat;
         m_d[1] = esum;
         if (m_v[5]) m_out = m_d[5];
      end
      #1;
      check({name, ".valid_out"}, {31'd0, valid_out}, {31'd0, m_v[5]});
      check({name, ".pxl_out"}, pxl_out, m_out);
   endtask

   initial begin
      int run_len;
      int max_run;

      vecs[0] = '{32'h0000_0001, 32'h0, 32'h0000_0020, "all_one"};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFE0, "all_m1"};
`ifdef ADD32LAYERS_SAT_EN
      vecs[2] = '{32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, "all_max"};
      vecs[3] = '{32'h8000_0000, 32'h0, 32'h8000_0000, "all_min"};
      vecs[4] = '{32'h4000_0000, 32'h0, 32'h7FFF_FFFF, "big_pos"};
`else
      vecs[2] = '{32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFE0, "all_max"};
      vecs[3] = '{32'h8000_0000, 32'h0, 32'h0000_0000, "all_min"};
      vecs[4] = '{32'h4000_0000, 32'h0, 32'h0000_0000, "big_pos"};
`endif
      vecs[5] = '{32'h0000_0000, 32'h1, 32'h0000_01F0, "ramp"};
      vecs[6] = '{32'd100, 32'hFFFF_FFFD, 32'h0000_06B0, "ramp_down"};
      vecs[7] = '{32'h0000_1000, 32'h0, 32'h0002_0000, "lane_4096"};

      for (int k = 1; k <= 5; k++) begin
         m_v[k] = 1'b0;
         m_d[k] = '0;
      end
      m_out = '0;

      // Reset with valid beats present; they must be discarded.
      rst = 1'b0;
      drive(32'd5, 32'd0, 1'b1);
      cycle("reset0", 32'd0);
      cycle("reset1", 32'd0);
      rst = 1'b1;
      drive(32'd0, 32'd0, 1'b0);
      for (int c = 0; c < 6; c++) cycle("post_reset_idle", 32'd0);

      // Table vectors: one beat, then idle until it drains and is held.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].base, vecs[i].step, 1'b1);
         cycle(vecs[i].name, vecs[i].exp);
         drive(32'd0, 32'd0, 1'b0);
         for (int c = 0; c < 6; c++) cycle(vecs[i].name, 32'd0);
      end

      // Back-to-back stream of ten beats, i = 1..10.
      run_len = 0;
      max_run = 0;
      for (int i = 1; i <= 16; i++) begin
         if (i <= 10) drive(i, 32'd0, 1'b1);
         else drive(32'd0, 32'd0, 1'b0);
         cycle("stream", i * 32);
         if (valid_out) run_len++;
         else run_len = 0;
         if (run_len > max_run) max_run = run_len;
      end
      check("stream_run_len", max_run, 32'd10);

      // A single beat with valid_in_17 low inside a stream.
      for (int i = 1; i <= 13; i++) begin
         if (i <= 8) drive(i + 20, 32'd0, 1'b1);
         else drive(32'd0, 32'd0, 1'b0);
         if (i == 4) vin[16] = 1'b0;
         cycle("gap17", (i + 20) * 32);
      end

      // Reset pulse mid-stream: in-flight beats are lost.
      for (int i = 1; i <= 14; i++) begin
         if (i <= 9) drive(i + 40, 32'd0, 1'b1);
         else drive(32'd0, 32'd0, 1'b0);
         rst = (i != 4);
         cycle("mid_reset", (i + 40) * 32);
         if (i == 4) begin
            check("mid_reset.valid_zero", {31'd0, valid_out}, 32'd0);
            check("mid_reset.pxl_zero", pxl_out, 32'd0);
         end
      end
      rst = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
